// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Multi-cycle data memory. Accepts one word-aligned request at a
//             time over valid/ready, waits a fixed LATENCY, then holds the
//             response until the requester accepts it.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);
    // Counter only has to hold LATENCY-1; keep at least one bit for LATENCY=1
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:2]          r_addr;
    logic                 r_ren;
    logic                 r_wen;
    logic [31:0]          r_wdata;
    logic [3:0]           r_mask;
    logic [31:0]          r_rdata;
    logic                 r_err;

    logic [31:0]          r_mem [DEPTH_WORDS];

    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_addr_hi;
    logic                 w_err;
    logic [31:0]          w_lane_mask;
    logic                 w_access;
    logic                 w_mem_we;
    logic [31:0]          w_rdata;
    logic                 w_unused_addr_lsb;

    // Byte offset bits carry no information for word accesses
    assign w_unused_addr_lsb = ^i_req_addr[1:0];

    // Decode of the latched request, used only on the access cycle
    assign w_idx       = r_addr[c_IDX_W+1:2];
    assign w_addr_hi   = |r_addr[31:c_IDX_W+2];
    assign w_err       = (r_ren == r_wen) || w_addr_hi;
    assign w_lane_mask = {{8{r_mask[3]}}, {8{r_mask[2]}}, {8{r_mask[1]}}, {8{r_mask[0]}}};
    assign w_access    = (r_state == ST_BUSY) && (r_cnt == '0);
    // Reset forces IDLE asynchronously, so an abandoned write never commits
    assign w_mem_we    = w_access && !w_err && r_wen && !i_rst;
    assign w_rdata     = r_mem[w_idx] & w_lane_mask;

    assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;

    // Storage array: byte-lane writes, contents untouched by reset
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request/latency/response sequencer with registered response fields
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_addr  <= i_req_addr[31:2];
                        r_ren   <= i_req_ren;
                        r_wen   <= i_req_wen;
                        r_wdata <= i_req_wdata;
                        r_mask  <= i_req_mask;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else begin
                        r_err   <= w_err;
                        r_rdata <= (!w_err && r_ren) ? w_rdata : 32'd0;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder (LATENCY 2, 1 and 5).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic        rsp_err   [3];
    logic [31:0] rsp_rdata [3];
    logic [31:0] req_addr;
    logic        req_ren;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference memory of the LATENCY=2 instance, keyed by word index
    logic [31:0] model [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_addr(req_addr), .i_req_ren(req_ren), .i_req_wen(req_wen),
        .i_req_wdata(req_wdata), .i_req_mask(req_mask), .o_rsp_valid(rsp_valid[0]),
        .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_addr(req_addr), .i_req_ren(req_ren), .i_req_wen(req_wen),
        .i_req_wdata(req_wdata), .i_req_mask(req_mask), .o_rsp_valid(rsp_valid[1]),
        .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(5)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
        .i_req_addr(req_addr), .i_req_ren(req_ren), .i_req_wen(req_wen),
        .i_req_wdata(req_wdata), .i_req_mask(req_mask), .o_rsp_valid(rsp_valid[2]),
        .i_rsp_ready(rsp_ready[2]), .o_rsp_rdata(rsp_rdata[2]), .o_rsp_err(rsp_err[2]));

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[8*b +: 8] = {8{m[b]}};
        return v;
    endfunction

    // Behavioural memory: 1024 words, byte address, illegal ops have no effect
    function automatic void model_op(input logic [31:0] a, input logic r, input logic w,
                                     input logic [31:0] d, input logic [3:0] m,
                                     output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        idx     = int'(a / 4) % 1024;
        exp_err = (r == w) || (a >= 32'd4096);
        exp_rd  = 32'd0;
        if (!exp_err && r) exp_rd = model[idx] & lanes(m);
        if (!exp_err && w) model[idx] = (model[idx] & ~lanes(m)) | (d & lanes(m));
    endfunction

    // One full request/response exchange on instance s; entered and left at posedge+1
    task automatic xact(input int s, input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] d, input logic [3:0] m,
                        output logic [31:0] rd, output logic e, output int lat, output int acc);
        int t;
        t = 0;
        while (req_ready[s] !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL ready_timeout inst=%0d: ready=%b, required 1", s, req_ready[s]);
        end
        req_addr = a; req_ren = r; req_wen = w; req_wdata = d; req_mask = m;
        req_valid[s] = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        req_valid[s] = 1'b0;
        req_addr = $urandom; req_ren = 1'($urandom); req_wen = 1'($urandom);
        req_wdata = $urandom; req_mask = 4'($urandom);
        lat = 0;
        while (rsp_valid[s] !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_timeout inst=%0d: rsp_valid=%b, required 1", s, rsp_valid[s]);
        end
        rd = rsp_rdata[s];
        e  = rsp_err[s];
        rsp_ready[s] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[s] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", req_ready[0]); end
        n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid[0]); end
        n_cmp++; if (rsp_rdata[0] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h, required 0", rsp_rdata[0]); end
        n_cmp++; if (rsp_err[0] !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", rsp_err[0]); end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b, required 1", req_ready[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, erd; logic e, ee; int lat, acc;
        xact(0, 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, rd, e, lat, acc);
        model_op(32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, erd, ee);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL wr_latency: got %0d, required 2", lat); end
        n_cmp++; if (e !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL wr_rsp: got err=%b rdata=%h, required err=0 rdata=0", e, rd); end
        xact(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, rd, e, lat, acc);
        model_op(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, erd, ee);
        n_cmp++; if (rd !== 32'hDEADBEEF || rd !== erd || e !== 1'b0) begin n_fail++; $display("FAIL rd_word: got %h err=%b, required deadbeef err=0", rd, e); end
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL rd_latency: got %0d, required 2", lat); end
    endtask

    task automatic test_lanes();
        logic [31:0] rd, erd; logic e, ee; int lat, acc;
        xact(0, 32'h13, 1'b0, 1'b1, 32'hAA000000, 4'b1000, rd, e, lat, acc);
        model_op(32'h13, 1'b0, 1'b1, 32'hAA000000, 4'b1000, erd, ee);
        xact(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'b1111, rd, e, lat, acc);
        n_cmp++; if (rd !== 32'hAAADBEEF) begin n_fail++; $display("FAIL lane_byte3: got %h, required aaadbeef", rd); end
        xact(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'b0011, rd, e, lat, acc);
        n_cmp++; if (rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL lane_half: got %h, required 0000beef", rd); end
        xact(0, 32'h12, 1'b1, 1'b0, 32'h0, 4'b0000, rd, e, lat, acc);
        n_cmp++; if (rd !== 32'd0 || e !== 1'b0) begin n_fail++; $display("FAIL mask_zero: got %h err=%b, required 0 err=0", rd, e); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic e; int lat, acc, t;
        req_addr = 32'h10; req_ren = 1'b1; req_wen = 1'b0; req_wdata = 32'h0; req_mask = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        t = 0;
        while (rsp_valid[0] !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        n_cmp++; if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: rsp_valid=%b, required 1", rsp_valid[0]); end
        // A request offered while the response is pending must be ignored
        req_addr = 32'h10; req_ren = 1'b0; req_wen = 1'b1; req_wdata = 32'h0; req_mask = 4'hF;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hAAADBEEF || req_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid=%b rdata=%h ready=%b, required 1 aaadbeef 0",
                         i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
            end
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        n_cmp++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                     req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        end
        xact(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, rd, e, lat, acc);
        n_cmp++; if (rd !== 32'hAAADBEEF) begin n_fail++; $display("FAIL bp_no_write: got %h, required aaadbeef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic e, ee; int lat, acc;
        logic [31:0] a_tab [3] = '{32'h10, 32'h10, 32'h1010};
        logic        r_tab [3] = '{1'b1, 1'b0, 1'b0};
        logic        w_tab [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            xact(0, a_tab[i], r_tab[i], w_tab[i], $urandom, 4'hF, rd, e, lat, acc);
            model_op(a_tab[i], r_tab[i], w_tab[i], 32'h0, 4'hF, erd, ee);
            n_cmp++;
            if (e !== 1'b1 || rd !== 32'd0 || ee !== 1'b1) begin
                n_fail++;
                $display("FAIL err_case%0d: got err=%b rdata=%h, required err=1 rdata=0", i, e, rd);
            end
            xact(0, 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, rd, e, lat, acc);
            n_cmp++; if (rd !== 32'hAAADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL err_case%0d_after: got %h err=%b, required aaadbeef err=0", i, rd, e); end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd, erd; logic e, ee; int lat, acc, t;
        xact(0, 32'h20, 1'b0, 1'b1, 32'h0, 4'hF, rd, e, lat, acc);
        model_op(32'h20, 1'b0, 1'b1, 32'h0, 4'hF, erd, ee);
        req_addr = 32'h20; req_ren = 1'b0; req_wen = 1'b1; req_wdata = 32'h12345678; req_mask = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy_outputs: ready=%b valid=%b rdata=%h err=%b, required all 0",
                     req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL rst_busy_ready: got %b, required 1", req_ready[0]); end
        xact(0, 32'h20, 1'b1, 1'b0, 32'h0, 4'hF, rd, e, lat, acc);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_busy_discard: got %h, required 0", rd); end
        // Reset while the response waits: the committed write must survive
        req_addr = 32'h24; req_ren = 1'b0; req_wen = 1'b1; req_wdata = 32'hCAFEF00D; req_mask = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        model_op(32'h24, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, erd, ee);
        t = 0;
        while (rsp_valid[0] !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        rst = 1'b1; #1;
        n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_resp_drop: got %b, required 0", rsp_valid[0]); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        xact(0, 32'h24, 1'b1, 1'b0, 32'h0, 4'hF, rd, e, lat, acc);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_resp_keep: got %h, required cafef00d", rd); end
    endtask

    task automatic test_latency_sweep();
        logic [31:0] rd, d; logic e; int lat, acc0, acc1;
        int lat_tab [3] = '{2, 1, 5};
        for (int s = 0; s < 3; s++) begin
            d = $urandom;
            xact(s, 32'h40, 1'b0, 1'b1, d, 4'hF, rd, e, lat, acc0);
            n_cmp++; if (lat != lat_tab[s]) begin n_fail++; $display("FAIL sweep_wr_lat inst=%0d: got %0d, required %0d", s, lat, lat_tab[s]); end
            xact(s, 32'h40, 1'b1, 1'b0, 32'h0, 4'hF, rd, e, lat, acc1);
            n_cmp++; if (lat != lat_tab[s] || rd !== d) begin n_fail++; $display("FAIL sweep_rd inst=%0d: got lat=%0d rdata=%h, required %0d %h", s, lat, rd, lat_tab[s], d); end
            n_cmp++; if (acc1 - acc0 != lat_tab[s] + 2) begin n_fail++; $display("FAIL sweep_period inst=%0d: got %0d, required %0d", s, acc1 - acc0, lat_tab[s] + 2); end
            if (s == 0) model[16] = d;
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, d; logic e, ee, r, w; logic [3:0] m; int lat, acc, kind;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            xact(0, 32'(i * 4), 1'b0, 1'b1, d, 4'hF, rd, e, lat, acc);
            model_op(32'(i * 4), 1'b0, 1'b1, d, 4'hF, erd, ee);
        end
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            d = $urandom;
            m = 4'($urandom);
            case (kind)
                0: begin r = 1'b1; w = 1'b0; end
                1: begin r = 1'b0; w = 1'b1; end
                2: begin r = 1'b1; w = 1'b1; end
                3: begin r = 1'b0; w = 1'b0; end
                default: begin
                    r = 1'($urandom); w = ~r;
                    a = a | (32'd1 << $urandom_range(12, 31));
                end
            endcase
            xact(0, a, r, w, d, m, rd, e, lat, acc);
            model_op(a, r, w, d, m, erd, ee);
            n_cmp++;
            if (rd !== erd || e !== ee || lat != 2) begin
                n_fail++;
                $display("FAIL random_%0d a=%h r=%b w=%b m=%b: got rdata=%h err=%b lat=%0d, required %h %b 2",
                         i, a, r, w, m, rd, e, lat, erd, ee);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        req_addr = '0; req_ren = 1'b0; req_wen = 1'b0; req_wdata = '0; req_mask = '0;
        for (int s = 0; s < 3; s++) begin req_valid[s] = 1'b0; rsp_ready[s] = 1'b0; end
        #1;
        test_reset();
        test_write_read();
        test_lanes();
        test_backpressure();
        test_errors();
        test_reset_mid_write();
        test_latency_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
